// File: rtl/pipeline_op_tracker.sv
// Five-stage op/func tracker with RAW-hazard stall and branch flush.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module pipeline_op_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        br_taken,
  output logic [3:0]  IF_op,
  output logic [3:0]  IF_func,
  output logic [3:0]  DEC_op,
  output logic [3:0]  DEC_func,
  output logic [3:0]  EX_op,
  output logic [3:0]  EX_func,
  output logic [3:0]  ME_op,
  output logic [3:0]  ME_func,
  output logic [3:0]  WB_op,
  output logic [3:0]  WB_func,
  output logic        stall,
`ifdef HAZARD_STATS_EN
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic        flush
);

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } entry_t;

  localparam entry_t BUBBLE = '{
    op: 4'b0010, func: 4'b0011,
    rd: 4'd0, rs1: 4'd0, rs2: 4'd0
  };

  entry_t if_q, if_d;
  entry_t dec_q, dec_d;
  entry_t ex_q, ex_d;
  entry_t me_q, me_d;
  entry_t wb_q, wb_d;
  logic   flush_q, flush_d;

  function automatic logic is_bub(entry_t e);
    return (e.op == BUBBLE.op) && (e.func == BUBBLE.func);
  endfunction

  function automatic logic writes(entry_t e);
    case (e.op)
      4'b1100, 4'b0100, 4'b0111,
      4'b1101, 4'b0101, 4'b0110: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic rd_rs2(entry_t e);
    if (is_bub(e)) return 1'b0;
    case (e.op)
      4'b1100, 4'b1101,
      4'b0011, 4'b0010: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic hit(entry_t d, entry_t w);
    logic r1;
    logic r2;
    r1 = !is_bub(d) && (d.rs1 == w.rd);
    r2 = rd_rs2(d) && (d.rs2 == w.rd);
    return writes(w) && (r1 || r2);
  endfunction

  logic hazard;
  logic br_hon;
  entry_t fetch;

  // Hazard detect, branch qualify and next-state for the stage registers
  always_comb begin
    hazard = hit(dec_q, ex_q) | hit(dec_q, me_q)
           | hit(dec_q, wb_q);
    br_hon = br_taken &&
             ((ex_q.op == 4'b0010) || (ex_q.op == 4'b0110));
    stall  = hazard && !br_hon;
    fetch  = instr_valid ? entry_t'(instr_in[31:12]) : BUBBLE;
    if_d    = fetch;
    dec_d   = if_q;
    ex_d    = dec_q;
    me_d    = ex_q;
    wb_d    = me_q;
    flush_d = br_hon;
    if (br_hon) begin
      if_d  = BUBBLE;
      dec_d = BUBBLE;
      ex_d  = BUBBLE;
    end else if (stall) begin
      if_d  = if_q;
      dec_d = dec_q;
      ex_d  = BUBBLE;
    end
  end

  // Stage registers and registered flush
  always_ff @(posedge clk) begin
    if (reset) begin
      if_q    <= BUBBLE;
      dec_q   <= BUBBLE;
      ex_q    <= BUBBLE;
      me_q    <= BUBBLE;
      wb_q    <= BUBBLE;
      flush_q <= 1'b0;
    end else begin
      if_q    <= if_d;
      dec_q   <= dec_d;
      ex_q    <= ex_d;
      me_q    <= me_d;
      wb_q    <= wb_d;
      flush_q <= flush_d;
    end
  end

  assign IF_op    = if_q.op;
  assign IF_func  = if_q.func;
  assign DEC_op   = dec_q.op;
  assign DEC_func = dec_q.func;
  assign EX_op    = ex_q.op;
  assign EX_func  = ex_q.func;
  assign ME_op    = me_q.op;
  assign ME_func  = me_q.func;
  assign WB_op    = wb_q.op;
  assign WB_func  = wb_q.func;
  assign flush    = flush_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_q && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_op_tracker.sv
// Directed bench for pipeline_op_tracker.
// Define HAZARD_STATS_EN to also check the counters.
module tb_pipeline_op_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        br_taken;
  logic [3:0]  IF_op, IF_func, DEC_op, DEC_func;
  logic [3:0]  EX_op, EX_func, ME_op, ME_func;
  logic [3:0]  WB_op, WB_func;
  logic        stall, flush;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  pipeline_op_tracker dut (
    .clk(clk), .reset(reset),
    .instr_in(instr_in), .instr_valid(instr_valid),
    .br_taken(br_taken),
    .IF_op(IF_op), .IF_func(IF_func),
    .DEC_op(DEC_op), .DEC_func(DEC_func),
    .EX_op(EX_op), .EX_func(EX_func),
    .ME_op(ME_op), .ME_func(ME_func),
    .WB_op(WB_op), .WB_func(WB_func),
    .stall(stall),
`ifdef HAZARD_STATS_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .flush(flush)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [7:0] BU = 8'h23;

  wire [39:0] stg = {IF_op, IF_func, DEC_op, DEC_func,
                     EX_op, EX_func, ME_op, ME_func,
                     WB_op, WB_func};

  task automatic check(input string tag,
                       input logic [39:0] got,
                       input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] st(input logic [7:0] a,
      input logic [7:0] b, input logic [7:0] c,
      input logic [7:0] d, input logic [7:0] e);
    return {a, b, c, d, e};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    br_taken = 1'b0;
    instr_in = 32'h0;
    step();
    reset = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w, input logic v);
    instr_in = w;
    instr_valid = v;
    step();
  endtask

  logic [39:0] exp3 [9];
  logic        stl3 [9];

  initial begin
    reset = 1'b1;
    instr_in = 32'h0;
    instr_valid = 1'b0;
    br_taken = 1'b0;
    step();

    // idle after reset
    do_reset();
    check("rst_stages", stg, {5{BU}});
    check("rst_stall", 40'(stall), 40'd0);
    check("rst_flush", 40'(flush), 40'd0);
    for (int i = 0; i < 6; i++) begin
      feed(32'h0, 1'b0);
      check($sformatf("idle%0d_st", i), stg, {5{BU}});
      check($sformatf("idle%0d_stall", i), 40'(stall), 40'd0);
      check($sformatf("idle%0d_flush", i), 40'(flush), 40'd0);
    end

    // independent ADDs
    do_reset();
    feed(32'hC7123000, 1'b1);
    check("ind1", stg, st(8'hC7, BU, BU, BU, BU));
    feed(32'hC0456000, 1'b1);
    check("ind2", stg, st(8'hC0, 8'hC7, BU, BU, BU));
    check("ind2_stall", 40'(stall), 40'd0);
    feed(32'h0, 1'b0);
    check("ind3", stg, st(BU, 8'hC0, 8'hC7, BU, BU));
    check("ind3_stall", 40'(stall), 40'd0);
    feed(32'h0, 1'b0);
    check("ind4", stg, st(BU, BU, 8'hC0, 8'hC7, BU));
    check("ind4_stall", 40'(stall), 40'd0);
    feed(32'h0, 1'b0);
    check("ind5", stg, st(BU, BU, BU, 8'hC0, 8'hC7));
    feed(32'h0, 1'b0);
    check("ind6", stg, st(BU, BU, BU, BU, 8'hC0));

    // ADDI r1 then dependent ADD r2,r1,r3
    exp3[0] = st(8'h47, BU, BU, BU, BU);    stl3[0] = 0;
    exp3[1] = st(8'hC7, 8'h47, BU, BU, BU); stl3[1] = 0;
    exp3[2] = st(BU, 8'hC7, 8'h47, BU, BU); stl3[2] = 1;
    exp3[3] = st(BU, 8'hC7, BU, 8'h47, BU); stl3[3] = 1;
    exp3[4] = st(BU, 8'hC7, BU, BU, 8'h47); stl3[4] = 1;
    exp3[5] = st(BU, 8'hC7, BU, BU, BU);    stl3[5] = 0;
    exp3[6] = st(BU, BU, 8'hC7, BU, BU);    stl3[6] = 0;
    exp3[7] = st(BU, BU, BU, 8'hC7, BU);    stl3[7] = 0;
    exp3[8] = st(BU, BU, BU, BU, 8'hC7);    stl3[8] = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) feed(32'h47100000, 1'b1);
      else if (i == 1) feed(32'hC7213000, 1'b1);
      else feed(32'h0, 1'b0);
      check($sformatf("raw%0d_st", i), stg, exp3[i]);
      check($sformatf("raw%0d_stall", i),
            40'(stall), 40'(stl3[i]));
    end
`ifdef HAZARD_STATS_EN
    check("raw_stall_cnt", 40'(stall_cnt), 40'd3);
`endif

    // honored branch
    do_reset();
    feed(32'h22000000, 1'b1);
    feed(32'hC7456000, 1'b1);
    feed(32'hC0789000, 1'b1);
    check("br3", stg, st(8'hC0, 8'hC7, 8'h22, BU, BU));
    check("br3_flush", 40'(flush), 40'd0);
    check("br3_stall", 40'(stall), 40'd0);
    br_taken = 1'b1;
    feed(32'hC7ABC000, 1'b1);
    br_taken = 1'b0;
    check("br4", stg, st(BU, BU, BU, 8'h22, BU));
    check("br4_flush", 40'(flush), 40'd1);
    feed(32'h0, 1'b0);
    check("br5", stg, st(BU, BU, BU, BU, 8'h22));
    check("br5_flush", 40'(flush), 40'd0);
`ifdef HAZARD_STATS_EN
    check("br_flush_cnt", 40'(flush_cnt), 40'd1);
`endif

    // br_taken with ADD in EX is ignored
    do_reset();
    feed(32'hC7123000, 1'b1);
    feed(32'hC0456000, 1'b1);
    feed(32'h0, 1'b0);
    check("nbr3", stg, st(BU, 8'hC0, 8'hC7, BU, BU));
    br_taken = 1'b1;
    feed(32'h0, 1'b0);
    br_taken = 1'b0;
    check("nbr4", stg, st(BU, BU, 8'hC0, 8'hC7, BU));
    check("nbr4_flush", 40'(flush), 40'd0);

    // reset during a stall
    do_reset();
    feed(32'h47100000, 1'b1);
    feed(32'hC7213000, 1'b1);
    feed(32'h0, 1'b0);
    check("rs_pre_stall", 40'(stall), 40'd1);
    reset = 1'b1;
    instr_in = 32'hC7123000;
    instr_valid = 1'b1;
    step();
    reset = 1'b0;
    instr_valid = 1'b0;
    check("rs_st", stg, {5{BU}});
    check("rs_stall", 40'(stall), 40'd0);
    check("rs_flush", 40'(flush), 40'd0);
`ifdef HAZARD_STATS_EN
    check("rs_stall_cnt", 40'(stall_cnt), 40'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
